// File: rtl/booth_mult_pkg.sv
// rtl/booth_mult_pkg.sv - shared constants, enums and Booth digit decode for booth_mult
// Purpose: the operand width, the step count, the FSM state enum and the radix-4 Booth
//          digit decode used by booth_mult and booth_step.
// Ports:   none (package).
package booth_mult_pkg;

    localparam int WIDTH   = 32;
    localparam int N_STEPS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        PA   = 3'd1,
        P2A  = 3'd2,
        MA   = 3'd3,
        M2A  = 3'd4
    } sel_e;

    // Radix-4 Booth recoding of {b[i+1], b[i], b[i-1]}.
    function automatic sel_e booth_sel(input logic [2:0] bits);
        case (bits)
            3'b001, 3'b010: booth_sel = PA;
            3'b011:         booth_sel = P2A;
            3'b100:         booth_sel = M2A;
            3'b101, 3'b110: booth_sel = MA;
            default:        booth_sel = ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-4 Booth step (add, then arithmetic shift by 2)
// Purpose: adds the Booth-selected multiple of A to the 34-bit upper field of the product
//          register and returns the whole register shifted arithmetically right by 2.
// Ports:   booth_bits_i - product register bits [2:0] (current Booth digit)
//          upper_i      - product register bits [66:33]
//          lower_i      - product register bits [32:2] (the part that survives the shift)
//          a_i          - signed multiplicand
//          next_o       - next 67-bit product register value
module booth_step
    import booth_mult_pkg::*;
(
    input  logic [2:0]        booth_bits_i,
    input  logic [33:0]       upper_i,
    input  logic [30:0]       lower_i,
    input  logic [WIDTH-1:0]  a_i,
    output logic [66:0]       next_o
);

    logic [33:0] a_ext;
    logic [33:0] a2_ext;
    logic [33:0] addend;
    logic [33:0] sum;
    sel_e        sel;

    // 34 bits give headroom for +/-2A, including 2 * 0x80000000.
    assign a_ext  = {{2{a_i[WIDTH-1]}}, a_i};
    assign a2_ext = {a_i[WIDTH-1], a_i, 1'b0};
    assign sel    = booth_sel(booth_bits_i);

    always_comb begin
        addend = '0;
        case (sel)
            PA:      addend = a_ext;
            P2A:     addend = a2_ext;
            MA:      addend = ~a_ext + 34'd1;
            M2A:     addend = ~a2_ext + 34'd1;
            default: addend = '0;
        endcase
    end

    assign sum    = upper_i + addend;
    assign next_o = {sum[33], sum[33], sum, lower_i};

endmodule

// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - 32x32 signed radix-4 Booth multiplier, 16 iterations
// Purpose: multi-cycle signed multiplier returning the low 32 bits of the product.
//          Optional macro BOOTH_MULT_OVF_EN builds signed 32-bit overflow detection;
//          without it data_exception is tied to 0.
// Ports:   clk            - rising-edge clock
//          reset          - synchronous active-high reset
//          ctrl_MULT      - one-cycle start pulse (restarts any operation in flight)
//          data_operandA  - signed multiplicand, sampled on start
//          data_operandB  - signed multiplier, sampled on start
//          data_result    - low 32 bits of the product, valid from DONE until next start
//          data_exception - signed overflow flag, valid alongside data_result
//          data_resultRDY - one-cycle result-valid pulse
//          busy           - high while iterating
module booth_mult
    import booth_mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_MULT,
    input  logic [WIDTH-1:0]  data_operandA,
    input  logic [WIDTH-1:0]  data_operandB,
    output logic [WIDTH-1:0]  data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic [66:0]       prod_q, prod_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic [66:0]       step_next;

    booth_step u_step (
        .booth_bits_i (prod_q[2:0]),
        .upper_i      (prod_q[66:33]),
        .lower_i      (prod_q[32:2]),
        .a_i          (a_q),
        .next_o       (step_next)
    );

`ifdef BOOTH_MULT_OVF_EN
    logic exc_q, exc_d;
    logic ovf;
    // After the last step the 64-bit product sits in [64:1]; it fits in 32 signed
    // bits only when [64:32] are all copies of the sign.
    assign ovf = ~((&step_next[64:32]) | ~(|step_next[64:32]));
    assign data_exception = exc_q;
`else
    assign data_exception = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        prod_d   = prod_q;
        a_d      = a_q;
        result_d = result_q;
`ifdef BOOTH_MULT_OVF_EN
        exc_d    = exc_q;
`endif
        if (ctrl_MULT) begin
            a_d     = data_operandA;
            prod_d  = {34'b0, data_operandB, 1'b0};
            count_d = 4'd0;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    prod_d  = step_next;
                    count_d = count_q + 4'd1;
                    if (count_q == 4'(N_STEPS - 1)) begin
                        state_d  = DONE;
                        result_d = step_next[32:1];
`ifdef BOOTH_MULT_OVF_EN
                        exc_d    = ovf;
`endif
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
        // Outputs are registered copies of the next state's decode.
        rdy_d  = (state_d == DONE);
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            prod_q   <= '0;
            a_q      <= '0;
            result_q <= '0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef BOOTH_MULT_OVF_EN
            exc_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            prod_q   <= prod_d;
            a_q      <= a_d;
            result_q <= result_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
`ifdef BOOTH_MULT_OVF_EN
            exc_q    <= exc_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: doc/booth_mult.md
BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, which is the single rising-edge clock.
REQ-002 The block SHALL have the port reset, input, 1 bit, which is a synchronous, active-high reset.
REQ-003 The block SHALL have the port ctrl_MULT, input, 1 bit, which is a one-cycle start pulse.
REQ-004 The block SHALL have the port data_operandA, input, 32 bits, which is the signed multiplicand and is sampled only on a start.
REQ-005 The block SHALL have the port data_operandB, input, 32 bits, which is the signed multiplier and is sampled only on a start.
REQ-006 The block SHALL have the port data_result, output, 32 bits, which carries the low 32 bits of the product.
REQ-007 The block SHALL have the port data_exception, output, 1 bit, which flags signed 32-bit overflow.
REQ-008 The block SHALL have the port data_resultRDY, output, 1 bit, which pulses for one cycle when the result is valid.
REQ-009 The block SHALL have the port busy, output, 1 bit, which is high while iterations are in progress.

Function
REQ-010 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 When ctrl_MULT is sampled high in any state, the block SHALL:
  - latch the operands,
  - load the product register as {34'b0, data_operandB, 1'b0},
  - clear the step count to 0,
  - enter RUN.
REQ-012 A ctrl_MULT that arrives during RUN or DONE SHALL abort the current operation and restart it; no data_resultRDY SHALL be produced for the aborted operation.
REQ-013 Each RUN edge SHALL perform one radix-4 Booth step:
  - select from product bits [2:0]: 000/111 -> 0, 001/010 -> +A, 011 -> +2A, 100 -> -2A, 101/110 -> -A;
  - add the selected value to the 34-bit upper field using sign-extended A;
  - shift the whole register arithmetically right by 2.
REQ-014 RUN SHALL last exactly 16 edges (step count 0..15); the edge that completes step 15 SHALL enter DONE.
REQ-015 data_resultRDY SHALL be high only during the single cycle in DONE; DONE SHALL then return to IDLE.
REQ-016 The total latency SHALL be: start edge E0, steps at E1..E16, data_resultRDY high in the cycle following E16.
REQ-017 data_result SHALL equal the product bits [32:1] (the low word) from DONE onward and SHALL hold until the next start.
REQ-018 busy SHALL be high in RUN only.
REQ-019 data_exception SHALL be valid alongside data_resultRDY and SHALL hold with data_result.
REQ-020 During RUN, data_result and data_exception SHALL be don't-care and the bench SHALL NOT check them.
REQ-021 All arithmetic SHALL be two's complement; an operand of 0x80000000 SHALL be handled correctly through -A and -2A with no special case.

Reset
REQ-022 On reset, the block SHALL set state to IDLE, the step count to 0, the product register to 0, and data_result, data_exception, data_resultRDY and busy to 0.
REQ-023 A reset asserted mid-RUN SHALL abandon the operation with no data_resultRDY.
REQ-024 Reset SHALL take priority over a simultaneous ctrl_MULT.

Configuration
REQ-025 The macro BOOTH_MULT_OVF_EN SHALL select whether overflow detection is built in.
  - Defined: data_exception = 1 when the 64-bit signed product does not fit in 32 bits, i.e. product bits [64:32] are not all equal.
  - Undefined: data_exception SHALL be tied to 0, and the overflow logic SHALL be absent.

Structure
REQ-026 The shared package SHALL hold:
  - the WIDTH=32 and N_STEPS=16 constants,
  - the state enum {IDLE, RUN, DONE},
  - the Booth-digit select enum {ZERO, PA, P2A, MA, M2A}.
REQ-027 The combinational sub-module booth_step SHALL:
  - take the 3 bits, the 34-bit upper field and A,
  - return the added and shifted next register value.
  The top level SHALL hold the FSM, the counter and the registers.

Verification
REQ-028 Start with A=3, B=4 -> data_resultRDY exactly 17 cycles after the start cycle; data_result=0x0000000C; data_exception=0.
REQ-029 A=-7, B=6 -> data_result=0xFFFFFFD6; data_exception=0.
REQ-030 A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE; data_exception=1 with the macro and 0 without it.
REQ-031 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000; data_exception=1 with the macro.
REQ-032 Start 5*5, re-pulse ctrl_MULT at step 8 with 9*9 -> a single data_resultRDY at 17 cycles after the second start; data_result=0x00000051.
REQ-033 Start, then assert reset at step 5 -> all outputs 0, state IDLE, no data_resultRDY within 20 cycles.
